// File: rtl/vga_icon_animator.sv
// Port sequencer in front of the VGA peripheral register interface: arbitrates CPU accesses
// against a per-frame animator that bounces the icon by rewriting the WX/HY words.
module vga_icon_animator #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic        cpu_address,
  input  logic [3:0]  cpu_byte_en,
  input  logic [31:0] cpu_data,
  output logic        cpu_ack,
  input  logic        frame_start,
  input  logic        anim_en,
  input  logic [3:0]  anim_step,
  input  logic [5:0]  icon_w,
  input  logic [9:0]  icon_x,
  input  logic [5:0]  icon_h,
  input  logic [9:0]  icon_y,
  output logic [31:0] data,
  output logic        address,
  output logic [3:0]  byte_en,
  output logic        rw,
  output logic        clken,
  output logic        dir_x,
  output logic        dir_y,
  output logic        frame_miss
);

  localparam logic [10:0] H_B = 11'(H_ACTIVE);
  localparam logic [10:0] V_B = 11'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, CALC, WR_WX, WR_HY} state_t;

  state_t      state, state_nx;
  logic        pending, pending_nx;
  logic [15:0] hy_word, hy_word_nx;
  logic [31:0] data_nx;
  logic        address_nx, rw_nx, clken_nx, cpu_ack_nx, miss_nx, dir_x_nx, dir_y_nx;
  logic [3:0]  byte_en_nx;
  logic        issue_cpu;
  logic [10:0] bx, by;

  // Result packs the new direction in bit 10 and the new 10-bit position below it.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic [5:0] size,
                                         input logic [3:0] step, input logic dir,
                                         input logic [10:0] bound);
    logic [10:0] p, sz, st, r;
    logic        d;
    p  = {1'b0, pos};
    sz = {5'b0, size};
    st = {7'b0, step};
    r  = '0;
    d  = 1'b0;
    if (sz > bound) begin
      r = '0;
      d = 1'b0;
    end else if (!dir) begin
      if (p + st + sz >= bound) begin
        r = bound - sz;
        d = 1'b1;
      end else begin
        r = p + st;
      end
    end else if (p > st) begin
      r = p - st;
      d = 1'b1;
    end
    return {d, r[9:0]};
  endfunction

  assign bx = bounce(icon_x, icon_w, anim_step, dir_x, H_B);
  assign by = bounce(icon_y, icon_h, anim_step, dir_y, V_B);

  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    hy_word_nx = hy_word;
    data_nx    = data;
    address_nx = address;
    byte_en_nx = byte_en;
    rw_nx      = rw;
    clken_nx   = 1'b0;
    cpu_ack_nx = 1'b0;
    miss_nx    = 1'b0;
    dir_x_nx   = dir_x;
    dir_y_nx   = dir_y;
    issue_cpu  = 1'b0;

    if (frame_start && anim_en) begin
      if (state == IDLE && !pending) pending_nx = 1'b1;
      else                           miss_nx    = 1'b1;
    end

    case (state)
      IDLE: begin
        if (pending) begin
          state_nx   = CALC;
          pending_nx = 1'b0;
        end else begin
          issue_cpu = cpu_req && !cpu_ack;
        end
      end
      CALC: begin
        dir_x_nx   = bx[10];
        dir_y_nx   = by[10];
        hy_word_nx = {icon_h, by[9:0]};
        clken_nx   = 1'b1;
        rw_nx      = 1'b0;
        address_nx = 1'b0;
        byte_en_nx = 4'b1100;
        data_nx    = {16'b0, icon_w, bx[9:0]};
        state_nx   = WR_WX;
      end
      WR_WX: begin
        clken_nx   = 1'b1;
        rw_nx      = 1'b0;
        address_nx = 1'b1;
        byte_en_nx = 4'b0011;
        data_nx    = {16'b0, hy_word};
        state_nx   = WR_HY;
      end
      WR_HY: begin
        // Hand the port straight back to a waiting CPU so its ack follows the HY strobe.
        state_nx  = IDLE;
        issue_cpu = cpu_req && !cpu_ack && !pending;
      end
      default: state_nx = IDLE;
    endcase

    if (issue_cpu) begin
      clken_nx   = 1'b1;
      cpu_ack_nx = 1'b1;
      rw_nx      = cpu_rw;
      address_nx = cpu_address;
      byte_en_nx = cpu_byte_en;
      data_nx    = cpu_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      hy_word    <= '0;
      data       <= '0;
      address    <= 1'b0;
      byte_en    <= '0;
      rw         <= 1'b0;
      clken      <= 1'b0;
      cpu_ack    <= 1'b0;
      frame_miss <= 1'b0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
    end else begin
      state      <= state_nx;
      pending    <= pending_nx;
      hy_word    <= hy_word_nx;
      data       <= data_nx;
      address    <= address_nx;
      byte_en    <= byte_en_nx;
      rw         <= rw_nx;
      clken      <= clken_nx;
      cpu_ack    <= cpu_ack_nx;
      frame_miss <= miss_nx;
      dir_x      <= dir_x_nx;
      dir_y      <= dir_y_nx;
    end
  end

endmodule

// File: tb/tb_vga_icon_animator.sv
// Bench for vga_icon_animator: directed scenarios then random traffic, all checked against a
// timeline model (frame accepted at edge T owns the port at edges T+2 and T+3).
module tb_vga_icon_animator;

  logic        clk = 1'b0;
  logic        nreset;
  logic        cpu_req, cpu_rw, cpu_address;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_data;
  logic        cpu_ack;
  logic        frame_start, anim_en;
  logic [3:0]  anim_step;
  logic [5:0]  icon_w, icon_h;
  logic [9:0]  icon_x, icon_y;
  logic [31:0] data;
  logic        address, rw, clken, dir_x, dir_y, frame_miss;
  logic [3:0]  byte_en;

  vga_icon_animator #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk(clk), .nreset(nreset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_address(cpu_address),
    .cpu_byte_en(cpu_byte_en), .cpu_data(cpu_data), .cpu_ack(cpu_ack),
    .frame_start(frame_start), .anim_en(anim_en), .anim_step(anim_step),
    .icon_w(icon_w), .icon_x(icon_x), .icon_h(icon_h), .icon_y(icon_y),
    .data(data), .address(address), .byte_en(byte_en), .rw(rw), .clken(clken),
    .dir_x(dir_x), .dir_y(dir_y), .frame_miss(frame_miss)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int n_strobe = 0;

  task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          cyc;
  int          t_pend;
  bit          m_ack, m_dx, m_dy;
  int          m_hy;

  task automatic model_reset();
    cyc = 0;
    t_pend = -100;
    m_ack = 0;
    m_dx = 0;
    m_dy = 0;
    m_hy = 0;
  endtask

  function automatic int nextpos(input int p, input int sz, input int st, input int bound,
                                 input bit d, output bit dn);
    if (sz > bound) begin
      dn = 0;
      return 0;
    end
    if (!d) begin
      if (p + st + sz >= bound) begin
        dn = 1;
        return bound - sz;
      end
      dn = 0;
      return p + st;
    end
    if (p <= st) begin
      dn = 0;
      return 0;
    end
    dn = 1;
    return p - st;
  endfunction

  task automatic step();
    bit          e_clk, e_ack, e_miss, pend_new, dn;
    logic [37:0] e_txn;
    int          xn, yn;
    e_clk = 0; e_ack = 0; e_miss = 0; pend_new = 0; e_txn = '0;
    if (frame_start && anim_en) begin
      if (cyc >= t_pend + 5) pend_new = 1;
      else                   e_miss = 1;
    end
    if (cyc == t_pend + 2) begin
      xn = nextpos(int'(icon_x), int'(icon_w), int'(anim_step), 640, m_dx, dn);
      m_dx = dn;
      yn = nextpos(int'(icon_y), int'(icon_h), int'(anim_step), 480, m_dy, dn);
      m_dy = dn;
      m_hy = int'(icon_h) * 1024 + yn;
      e_clk = 1;
      e_txn = {1'b0, 1'b0, 4'b1100, 32'(int'(icon_w) * 1024 + xn)};
    end else if (cyc == t_pend + 3) begin
      e_clk = 1;
      e_txn = {1'b0, 1'b1, 4'b0011, 32'(m_hy)};
    end else if (cpu_req && !m_ack && !(cyc >= t_pend + 1 && cyc <= t_pend + 3)) begin
      e_clk = 1;
      e_ack = 1;
      e_txn = {cpu_rw, cpu_address, cpu_byte_en, cpu_data};
    end
    m_ack = e_ack;
    if (pend_new) t_pend = cyc;
    cyc++;
    @(posedge clk);
    #1;
    if (clken) n_strobe++;
    chk("clken", 38'(clken), 38'(e_clk));
    chk("cpu_ack", 38'(cpu_ack), 38'(e_ack));
    chk("frame_miss", 38'(frame_miss), 38'(e_miss));
    chk("dirs", 38'({dir_x, dir_y}), 38'({m_dx, m_dy}));
    if (e_clk) chk("txn", {rw, address, byte_en, data}, e_txn);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #1;
    chk("rst_clken", 38'(clken), 38'(0));
    chk("rst_dirs", 38'({dir_x, dir_y}), 38'(0));
    chk("rst_ack", 38'(cpu_ack), 38'(0));
    model_reset();
    cpu_req = 1'b0;
    frame_start = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  function automatic logic [9:0] pick_pos(input int bound);
    case ($urandom_range(0, 2))
      0:       return 10'($urandom_range(0, 20));
      1:       return 10'(bound - 70 + int'($urandom_range(0, 69)));
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    nreset = 1'b0;
    cpu_req = 0; cpu_rw = 0; cpu_address = 0; cpu_byte_en = '0; cpu_data = '0;
    frame_start = 0; anim_en = 0; anim_step = '0;
    icon_w = '0; icon_x = '0; icon_h = '0; icon_y = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", {rw, address, byte_en, data}, 38'(0));
    chk("reset_ctl", 38'({clken, cpu_ack, frame_miss, dir_x, dir_y}), 38'(0));
    nreset = 1'b1;
    model_reset();

    // Idle CPU write
    cpu_req = 1; cpu_rw = 0; cpu_address = 0; cpu_byte_en = 4'b0001; cpu_data = 32'h0000_00E3;
    step();
    chk("t1_strobe", 38'({clken, cpu_ack}), 38'(2'b11));
    chk("t1_data", {rw, address, byte_en, data}, {2'b00, 4'b0001, 32'h0000_00E3});
    cpu_req = 0;
    step();
    chk("t1_single", 38'(clken), 38'(0));

    // Right bounce in x, bottom bounce in y
    anim_en = 1; anim_step = 4;
    icon_w = 32; icon_x = 606; icon_h = 20; icon_y = 460;
    frame_start = 1; step();
    frame_start = 0; step();
    step();
    chk("t2_wx", 38'(data), 38'(32'h0000_8260));
    chk("t2_dirx", 38'(dir_x), 38'(1));
    step();
    chk("t2_hy", 38'(data), 38'(32'h0000_51CC));
    chk("t2_diry", 38'(dir_y), 38'(1));
    step();

    // Left and top bounce
    icon_x = 3; icon_y = 2;
    frame_start = 1; step();
    frame_start = 0; step();
    step();
    chk("t3_wx", 38'(data), 38'(32'h0000_8000));
    chk("t3_dirx", 38'(dir_x), 38'(0));
    step();
    chk("t3_hy", 38'(data), 38'(32'h0000_5000));
    chk("t3_diry", 38'(dir_y), 38'(0));
    step();

    // Contention: CPU request arrives the cycle after the frame
    frame_start = 1; step();
    frame_start = 0;
    cpu_req = 1; cpu_rw = 1; cpu_address = 1; cpu_byte_en = 4'hF; cpu_data = $urandom;
    step();
    step();
    step();
    chk("t4_stalled", 38'(cpu_ack), 38'(0));
    step();
    chk("t4_ack", 38'({cpu_ack, address, rw}), 38'(3'b111));
    cpu_req = 0;
    step();

    // Overrun: second frame during WR_WX
    n_strobe = 0;
    frame_start = 1; step();
    frame_start = 0; step();
    step();
    frame_start = 1; step();
    chk("t5_miss", 38'(frame_miss), 38'(1));
    frame_start = 0;
    repeat (5) step();
    chk("t5_writes", 38'(n_strobe), 38'(2));

    // Reset while in WR_WX
    icon_x = 620;
    frame_start = 1; step();
    frame_start = 0; step();
    step();
    chk("t6_pre_dirx", 38'(dir_x), 38'(1));
    do_reset();
    n_strobe = 0;
    repeat (6) step();
    chk("t6_no_hy", 38'(n_strobe), 38'(0));

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (cpu_req && cpu_ack) begin
        cpu_req = 0;
      end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1;
        cpu_rw = 1'($urandom);
        cpu_address = 1'($urandom);
        cpu_byte_en = 4'($urandom);
        cpu_data = $urandom;
      end
      frame_start = ($urandom_range(0, 5) == 0);
      anim_en = ($urandom_range(0, 7) != 0);
      anim_step = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        icon_w = 6'($urandom);
        icon_h = 6'($urandom);
        icon_x = pick_pos(640);
        icon_y = pick_pos(480);
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
